// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// with packet lock and a retry when the transmitter never signals busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 8,
    parameter int GNT_W        = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_busy,
    output logic [GNT_W-1:0]              grant_id,
    output logic                          grant_active,
    output logic                          tx_timeout
);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [GNT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [GNT_W-1:0]      grant_id_q, grant_id_d;
    logic                  grant_active_q, grant_active_d;
    logic                  tx_timeout_q, tx_timeout_d;
    logic                  lock_q, lock_d;

    logic             win_ok;
    logic [GNT_W-1:0] win_idx;
    logic [GNT_W-1:0] sel;
    logic             accept;
    logic [GNT_W-1:0] rr_next;

    // Scan downwards so the index closest to rr_ptr is the last, winning assignment.
    always_comb begin
        int idx;
        idx     = 0;
        win_ok  = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                win_ok  = 1'b1;
                win_idx = GNT_W'(idx);
            end
        end
    end

    assign sel     = (state_q == HOLD) ? grant_id_q : win_idx;
    assign accept  = !tx_busy && ((state_q == ARB && win_ok) ||
                                  (state_q == HOLD && req_valid[grant_id_q]));
    assign rr_next = (grant_id_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GNT_W'(1);

    assign req_ready = (accept && RST) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : '0;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        tx_data_d      = tx_data_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        lock_d         = lock_q;
        tx_timeout_d   = 1'b0;
        case (state_q)
            ARB, HOLD: begin
                if (accept) begin
                    tx_data_d      = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d     = sel;
                    lock_d         = ~req_last[sel];
                    grant_active_d = 1'b1;
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    tx_timeout_d = 1'b1;
                    state_d      = LAUNCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lock_q) begin
                        state_d = HOLD;
                    end else begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = rr_next;
                        state_d        = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
        tx_valid_d = (state_d == LAUNCH);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ARB;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            tx_timeout_q   <= 1'b0;
            lock_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            tx_timeout_q   <= tx_timeout_d;
            lock_q         <= lock_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign tx_timeout   = tx_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench; a packet-level round-robin model predicts
// the order of acceptances and transmitted bytes, a monitor process compares them.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BT = 8;
    localparam int GW = 2;

    typedef struct packed {logic l; logic [DW-1:0] d;} rbyte_t;
    typedef struct packed {logic [GW-1:0] id; logic [DW-1:0] d; logic first;} exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_busy;
    logic [GW-1:0]   grant_id;
    logic            grant_active;
    logic            tx_timeout;
    logic            ext_busy = 1'b0;
    logic            u_busy = 1'b0;
    logic            uart_off = 1'b0;

    assign tx_busy = ext_busy | u_busy;
    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_active(grant_active), .tx_timeout(tx_timeout)
    );

    rbyte_t        rq[N][$];
    rbyte_t        mq[N][$];
    exp_t          exp_q[$];
    logic [GW-1:0] acc_q[$];
    int checks = 0, errors = 0;
    int m_ptr = 0, n_ready = 0, n_valid = 0, pop_idx = -1, u_dly = 0, u_cnt = 0;
    logic ga_dropped = 1'b0, prev_ready = 1'b0;
    logic [DW-1:0] last_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_pkt(input int id, input int len, input int d0);
        rbyte_t x;
        for (int b = 0; b < len; b++) begin
            x.d = (d0 >= 0 && b == 0) ? DW'(d0) : DW'($urandom);
            x.l = (b == len - 1);
            rq[id].push_back(x);
            mq[id].push_back(x);
        end
    endtask

    // Whole packets go out in round-robin order of requesters that have data pending.
    task automatic model();
        int w;
        rbyte_t x;
        logic first;
        forever begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
            if (w < 0) break;
            first = 1'b1;
            do begin
                x = mq[w].pop_front();
                exp_q.push_back({GW'(w), x.d, first});
                acc_q.push_back(GW'(w));
                first = 1'b0;
            end while (!x.l);
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!(exp_q.size() == 0 && acc_q.size() == 0 && !grant_active && !tx_busy) && c < budget);
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL drain: %0d bytes still expected after %0d cycles", exp_q.size(), c);
        end
    endtask

    // Monitor, requester driver and UART model.
    initial begin
        exp_t e;
        logic [GW-1:0] a;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (!grant_active) ga_dropped = 1'b1;
                if (prev_ready) chk("launch_latency", tx_valid, 1);
                if (req_ready != 0) begin
                    n_ready++;
                    chk("ready_onehot", $onehot(req_ready), 1);
                    if (acc_q.size() == 0) chk("unexpected_accept", req_ready, 0);
                    else begin
                        a = acc_q.pop_front();
                        chk("accept_id", req_ready, 32'(1) << a);
                    end
                    for (int i = 0; i < N; i++) if (req_ready[i]) pop_idx = i;
                end
                if (tx_valid) begin
                    n_valid++;
                    chk("valid_while_busy", tx_busy, 0);
                    if (!uart_off) u_dly = 2;
                    if (tx_timeout) chk("retry_data", tx_data, last_d);
                    else begin
                        chk("valid_after_accept", prev_ready, 1);
                        if (exp_q.size() == 0) chk("unexpected_valid", tx_valid, 0);
                        else begin
                            e = exp_q.pop_front();
                            chk("tx_data", tx_data, e.d);
                            chk("grant_id", grant_id, e.id);
                            chk("grant_active", grant_active, 1);
                            if (!e.first) chk("lock_hold", ga_dropped, 0);
                        end
                    end
                    ga_dropped = 1'b0;
                    last_d = tx_data;
                end
                if (tx_timeout) chk("timeout_with_valid", tx_valid, 1);
                prev_ready = (req_ready != 0);
            end else prev_ready = 1'b0;
            @(posedge CLK);
            #1;
            if (!RST) begin
                u_dly = 0;
                u_cnt = 0;
            end else if (u_dly > 0) begin
                u_dly--;
                if (u_dly == 0) u_cnt = $urandom_range(3, 12);
            end else if (u_cnt > 0) u_cnt--;
            u_busy = (u_cnt > 0);
            if (pop_idx >= 0 && rq[pop_idx].size() > 0) void'(rq[pop_idx].pop_front());
            pop_idx = -1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = rq[i].size() > 0;
                req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0].d : '0;
                req_last[i] = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
            end
        end
    end

    initial begin
        int t[3];
        int np, c, nr0, nv0;
        #12;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_tx_timeout", tx_timeout, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge CLK); #2; RST = 1'b1;
        @(posedge CLK); #2;
        // Round-robin from reset: 0,1,2,3,0.
        add_pkt(0, 1, -1); add_pkt(0, 1, -1); add_pkt(1, 1, -1); add_pkt(2, 1, -1); add_pkt(3, 1, -1);
        model();
        wait_done(500);
        // Packet lock: requester 1 owns the grant for three bytes while requester 0 waits.
        @(posedge CLK); #2;
        add_pkt(1, 3, -1); add_pkt(0, 1, -1);
        model();
        wait_done(500);
        // Single byte from requester 2, then rr_ptr=3 makes requester 3 beat requester 0.
        @(posedge CLK); #2;
        add_pkt(2, 1, 8'hA5);
        model();
        wait_done(300);
        @(posedge CLK); #2;
        add_pkt(0, 1, -1); add_pkt(3, 1, -1);
        model();
        wait_done(300);
        // Busy blocking.
        @(posedge CLK); #2;
        ext_busy = 1'b1;
        add_pkt(0, 2, -1); add_pkt(2, 1, -1);
        model();
        nr0 = n_ready; nv0 = n_valid;
        repeat (12) @(negedge CLK);
        chk("busy_block_ready", n_ready - nr0, 0);
        chk("busy_block_valid", n_valid - nv0, 0);
        @(posedge CLK); #2; ext_busy = 1'b0;
        wait_done(500);
        // Timeout: the UART never raises busy.
        @(posedge CLK); #2;
        uart_off = 1'b1;
        add_pkt(1, 1, -1);
        model();
        nr0 = n_ready; np = 0; c = 0;
        while (np < 3 && c < 100) begin
            @(negedge CLK);
            c++;
            if (tx_timeout) begin
                t[np] = c;
                np++;
            end
        end
        chk("timeout_pulses", np, 3);
        if (np == 3) begin
            chk("timeout_period_a", t[1] - t[0], BT + 1);
            chk("timeout_period_b", t[2] - t[1], BT + 1);
        end
        chk("timeout_no_reaccept", n_ready - nr0, 1);
        @(posedge CLK); #2; uart_off = 1'b0;
        wait_done(500);
        // Randomized batches.
        repeat (8) begin
            @(posedge CLK); #2;
            for (int i = 0; i < N; i++)
                repeat ($urandom_range(0, 2)) add_pkt(i, $urandom_range(1, 3), -1);
            model();
            wait_done(3000);
        end
        // Reset during WAIT_DONE.
        @(posedge CLK); #2;
        for (int i = 0; i < N; i++) add_pkt(i, 2, -1);
        model();
        c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!(tx_busy && grant_active) && c < 200);
        chk("reach_wait_done", tx_busy && grant_active, 1);
        #2; RST = 1'b0;
        #1;
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_grant_active", grant_active, 0);
        chk("mid_rst_tx_timeout", tx_timeout, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        acc_q.delete();
        m_ptr = 0;
        repeat (2) @(posedge CLK);
        #3; RST = 1'b1;
        @(posedge CLK); #2;
        for (int i = N - 1; i >= 0; i--) add_pkt(i, 1, -1);
        model();
        wait_done(1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end
endmodule
